vape_boundary_mr: RTL and testbench

Multi-region metadata-integrity monitor for the VAPE/ASAP hardware trust anchor: parametrised successor of the single-region boundary checker. It watches CPU data writes and DMA writes against NUM_REG independently configured protected regions plus the executable range (ER) entry point. It raises `exec` only while the ER execution started cleanly and no protected region has been written since. It additionally records which region(s) and which bus caused an abort, in sticky registers readable by the attestation logic.

---
 rtl/vape_boundary_mr.sv | 145 ++++++++++++++
 tb/tb_vape_boundary_mr.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vape_boundary_mr.sv
`default_nettype none
// ============================================================================
// Module   : vape_boundary_mr
// Purpose  : Multi-region metadata-integrity monitor. Watches CPU and DMA
//            writes against NUM_REG protected address ranges and the ER entry
//            point. Raises exec only while ER execution began cleanly and no
//            protected region has been written since. Records which
//            region(s) and which bus caused an abort in sticky registers.
// Ports    : clk, reset_n (async, active-low)
//            pc, data_addr/data_en, dma_addr/dma_en   - monitored buses
//            er_min, er_max                           - ER bounds (er_max is
//                                                       carried only)
//            reg_min, reg_max, reg_en                 - packed region config
//            clr_cause                                - clear sticky state
//            exec, viol_cause, viol_src, viol_cnt     - results
// Config   : VAPE_BOUNDARY_VIOL_CNT_EN - when defined, viol_cnt counts
//            EXEC->ABORT transitions (saturating); otherwise tied to 0.
// Revision : 1.0 - initial multi-region release
// ============================================================================
module vape_boundary_mr #(
   parameter int AW      = 16,
   parameter int NUM_REG = 2,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [AW-1:0]           pc,
   input  logic [AW-1:0]           data_addr,
   input  logic                    data_en,
   input  logic [AW-1:0]           dma_addr,
   input  logic                    dma_en,
   input  logic [AW-1:0]           er_min,
   input  logic [AW-1:0]           er_max,
   input  logic [NUM_REG*AW-1:0]   reg_min,
   input  logic [NUM_REG*AW-1:0]   reg_max,
   input  logic [NUM_REG-1:0]      reg_en,
   input  logic                    clr_cause,
   output logic                    exec,
   output logic [NUM_REG-1:0]      viol_cause,
   output logic [1:0]              viol_src,
   output logic [CNT_W-1:0]        viol_cnt
);

   typedef enum logic [0:0] {
      ST_ABORT = 1'b0,
      ST_EXEC  = 1'b1
   } state_t;

   state_t               r_state;
   logic [NUM_REG-1:0]   r_viol_cause;
   logic [1:0]           r_viol_src;

   logic [NUM_REG-1:0]   w_cpu_hit;
   logic [NUM_REG-1:0]   w_dma_hit;
   logic [NUM_REG-1:0]   w_hit;
   logic                 w_change;
   logic                 w_entry;
   logic                 w_unused_er_max;

   // er_max is only forwarded to attestation; it never influences decisions.
   assign w_unused_er_max = ^er_max;

   // Per-region inclusive range test. A region with min > max is disarmed.
   generate
      for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_region
         logic [AW-1:0] w_lo;
         logic [AW-1:0] w_hi;
         logic          w_armed;

         assign w_lo    = reg_min[gi*AW +: AW];
         assign w_hi    = reg_max[gi*AW +: AW];
         assign w_armed = reg_en[gi] & (w_lo <= w_hi);

         assign w_cpu_hit[gi] = w_armed & data_en &
                                (data_addr >= w_lo) & (data_addr <= w_hi);
         assign w_dma_hit[gi] = w_armed & dma_en &
                                (dma_addr >= w_lo) & (dma_addr <= w_hi);
      end
   endgenerate

   assign w_hit    = w_cpu_hit | w_dma_hit;
   assign w_change = |w_hit;
   assign w_entry  = (pc == er_min);

   // Zero-latency flag: a write in the current cycle kills it immediately,
   // and a clean ER entry raises it before the state register catches up.
   // Gating with reset_n keeps it low during reset even when pc == er_min.
   assign exec = reset_n & ~w_change & ((r_state == ST_EXEC) | w_entry);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_ABORT;
      end else begin
         case (r_state)
            ST_ABORT: if (w_entry && !w_change) r_state <= ST_EXEC;
            ST_EXEC:  if (w_change)             r_state <= ST_ABORT;
            default:                            r_state <= ST_ABORT;
         endcase
      end
   end

   // Sticky cause/source. On a clear, any hit in the same cycle is kept so
   // that a violation is never lost to a concurrent clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_viol_cause <= '0;
         r_viol_src   <= '0;
      end else if (clr_cause) begin
         r_viol_cause <= w_hit;
         r_viol_src   <= {|w_dma_hit, |w_cpu_hit};
      end else begin
         r_viol_cause <= r_viol_cause | w_hit;
         r_viol_src   <= r_viol_src | {|w_dma_hit, |w_cpu_hit};
      end
   end

   assign viol_cause = r_viol_cause;
   assign viol_src   = r_viol_src;

`ifdef VAPE_BOUNDARY_VIOL_CNT_EN
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_viol_cnt;
   logic             w_leave;

   assign w_leave = (r_state == ST_EXEC) & w_change;

   // Saturating abort counter; a clear coinciding with an abort leaves 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_viol_cnt <= '0;
      end else if (clr_cause) begin
         r_viol_cnt <= w_leave ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (w_leave && (r_viol_cnt != C_CNT_MAX)) begin
         r_viol_cnt <= r_viol_cnt + 1'b1;
      end
   end

   assign viol_cnt = r_viol_cnt;
`else
   assign viol_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vape_boundary_mr.sv
`default_nettype none
// ============================================================================
// Module   : tb_vape_boundary_mr
// Purpose  : Self-checking bench for vape_boundary_mr. A behavioural model
//            tracks "execution currently valid" plus the sticky cause/source
//            and counter, and is compared with the DUT every cycle. Directed
//            scenarios pin literal values; a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vape_boundary_mr;

   localparam int AW      = 16;
   localparam int NUM_REG = 2;
   localparam int CNT_W   = 8;

   logic                  clk;
   logic                  reset_n;
   logic [AW-1:0]         pc;
   logic [AW-1:0]         data_addr;
   logic                  data_en;
   logic [AW-1:0]         dma_addr;
   logic                  dma_en;
   logic [AW-1:0]         er_min;
   logic [AW-1:0]         er_max;
   logic [NUM_REG*AW-1:0] reg_min;
   logic [NUM_REG*AW-1:0] reg_max;
   logic [NUM_REG-1:0]    reg_en;
   logic                  clr_cause;
   logic                  exec;
   logic [NUM_REG-1:0]    viol_cause;
   logic [1:0]            viol_src;
   logic [CNT_W-1:0]      viol_cnt;

   int total = 0;
   int bad   = 0;

   vape_boundary_mr #(.AW(AW), .NUM_REG(NUM_REG), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pc         (pc),
      .data_addr  (data_addr),
      .data_en    (data_en),
      .dma_addr   (dma_addr),
      .dma_en     (dma_en),
      .er_min     (er_min),
      .er_max     (er_max),
      .reg_min    (reg_min),
      .reg_max    (reg_max),
      .reg_en     (reg_en),
      .clr_cause  (clr_cause),
      .exec       (exec),
      .viol_cause (viol_cause),
      .viol_src   (viol_src),
      .viol_cnt   (viol_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Which regions a write hits: enabled, well-formed, inclusive range.
   function automatic logic [NUM_REG-1:0] hits(input logic [AW-1:0] a, input logic en);
      logic [NUM_REG-1:0] h;
      logic [AW-1:0]      lo;
      logic [AW-1:0]      hi;
      h = '0;
      for (int i = 0; i < NUM_REG; i++) begin
         lo = reg_min[i*AW +: AW];
         hi = reg_max[i*AW +: AW];
         if (en && reg_en[i] && lo <= hi && a >= lo && a <= hi) h[i] = 1'b1;
      end
      return h;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   logic               m_valid;   // execution is valid as of the last edge
   logic [NUM_REG-1:0] m_cause;
   logic [1:0]         m_src;
   logic [CNT_W-1:0]   m_cnt;
   logic [NUM_REG-1:0] mc_cpu, mc_dma, mc_all;
   logic               mc_chg, mc_exec;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_valid = 1'b0;
         m_cause = '0;
         m_src   = '0;
         m_cnt   = '0;
         check("cyc_rst_exec",  {31'd0, exec}, 32'd0);
         check("cyc_rst_cause", {{(32-NUM_REG){1'b0}}, viol_cause}, 32'd0);
         check("cyc_rst_src",   {30'd0, viol_src}, 32'd0);
         check("cyc_rst_cnt",   {{(32-CNT_W){1'b0}}, viol_cnt}, 32'd0);
      end else begin
         mc_cpu  = hits(data_addr, data_en);
         mc_dma  = hits(dma_addr, dma_en);
         mc_all  = mc_cpu | mc_dma;
         mc_chg  = |mc_all;
         mc_exec = !mc_chg && (m_valid || pc == er_min);
         check("cyc_exec",  {31'd0, exec}, {31'd0, mc_exec});
         check("cyc_cause", {{(32-NUM_REG){1'b0}}, viol_cause}, {{(32-NUM_REG){1'b0}}, m_cause});
         check("cyc_src",   {30'd0, viol_src}, {30'd0, m_src});
         check("cyc_cnt",   {{(32-CNT_W){1'b0}}, viol_cnt}, {{(32-CNT_W){1'b0}}, m_cnt});
`ifdef VAPE_BOUNDARY_VIOL_CNT_EN
         if (clr_cause)                       m_cnt = (m_valid && mc_chg) ? 1 : 0;
         else if (m_valid && mc_chg && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
`endif
         m_cause = (clr_cause ? '0 : m_cause) | mc_all;
         m_src   = (clr_cause ? 2'b00 : m_src) | {|mc_dma, |mc_cpu};
         m_valid = mc_exec;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int r;
      logic [AW-1:0] lo, hi;
      r  = $urandom_range(0, NUM_REG-1);
      lo = reg_min[r*AW +: AW];
      hi = reg_max[r*AW +: AW];
      case ($urandom_range(0, 5))
         0:       return lo;
         1:       return hi;
         2:       return lo - 1'b1;
         3:       return hi + 1'b1;
         4:       return AW'($urandom);
         default: return lo + ((hi - lo) >> 1);
      endcase
   endfunction

   task automatic randomize_regions();
      logic [AW-1:0] lo;
      for (int i = 0; i < NUM_REG; i++) begin
         lo = AW'($urandom_range(0, 16'h03FF));
         reg_min[i*AW +: AW] = lo;
         if ($urandom_range(0, 5) == 0) reg_max[i*AW +: AW] = lo - AW'($urandom_range(1, 4));
         else                           reg_max[i*AW +: AW] = lo + AW'($urandom_range(0, 64));
      end
      reg_en = NUM_REG'($urandom);
   endtask

   logic [CNT_W-1:0] exp_cnt1;

   initial begin
`ifdef VAPE_BOUNDARY_VIOL_CNT_EN
      exp_cnt1 = 1;
`else
      exp_cnt1 = 0;
`endif
      reset_n   = 1'b0;
      pc        = 16'hE000;
      er_min    = 16'hE000;
      er_max    = 16'hE0FF;
      data_addr = '0;
      data_en   = 1'b0;
      dma_addr  = '0;
      dma_en    = 1'b0;
      reg_min   = {16'h0200, 16'h0140};
      reg_max   = {16'h02FF, 16'h016A};
      reg_en    = 2'b11;
      clr_cause = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_exec_low", {31'd0, exec}, 32'd0);
      check("reset_cause",    {30'd0, viol_cause}, 32'd0);

      // Clean entry right at reset release.
      reset_n = 1'b1;
      #1;
      check("entry_exec", {31'd0, exec}, 32'd1);

      // CPU write to region0 while in EXEC.
      step();
      data_en = 1'b1; data_addr = 16'h0140;
      #1;
      check("cpu_abort_exec", {31'd0, exec}, 32'd0);
      step();
      data_en = 1'b0;
      check("cpu_abort_cause", {30'd0, viol_cause}, 32'h1);
      check("cpu_abort_src",   {30'd0, viol_src},   32'h1);

      // Simultaneous DMA at region1 max and CPU at region0 min during entry.
      step();
      data_en = 1'b1; data_addr = 16'h0140;
      dma_en  = 1'b1; dma_addr  = 16'h02FF;
      #1;
      check("dual_exec", {31'd0, exec}, 32'd0);
      step();
      data_en = 1'b0; dma_en = 1'b0;
      check("dual_cause", {30'd0, viol_cause}, 32'h3);
      check("dual_src",   {30'd0, viol_src},   32'h3);

      // Clear alone.
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
      check("clr_cause", {30'd0, viol_cause}, 32'h0);
      check("clr_src",   {30'd0, viol_src},   32'h0);

      // Disarmed region1 (min > max): writes to 0x0200 are ignored.
      reg_max[AW +: AW] = 16'h01FF;
      data_en = 1'b1; data_addr = 16'h0200;
      dma_en  = 1'b1; dma_addr  = 16'h0200;
      #1;
      check("disarm_exec", {31'd0, exec}, 32'd1);
      step();
      reg_max[AW +: AW] = 16'h02FF;
      reg_en = 2'b01;
      #1;
      check("disable_exec", {31'd0, exec}, 32'd1);
      step();
      data_en = 1'b0; dma_en = 1'b0; reg_en = 2'b11;
      check("disable_cause", {30'd0, viol_cause}, 32'h0);

`ifdef VAPE_BOUNDARY_VIOL_CNT_EN
      // 256 EXEC->ABORT transitions saturate an 8-bit counter.
      for (int k = 0; k < 256; k++) begin
         step(); data_en = 1'b0;
         step(); data_en = 1'b1; data_addr = 16'h0150;
      end
      step();
      data_en = 1'b0;
      check("cnt_saturate", {24'd0, viol_cnt}, 32'hFF);
`endif

      // Clear alone (now in EXEC), then a DMA abort, re-entry, then clear
      // together with a CPU abort.
      step();
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
      check("clr_cnt", {24'd0, viol_cnt}, 32'd0);
      dma_en = 1'b1; dma_addr = 16'h0200;
      step();
      dma_en = 1'b0;
      check("pre_cause", {30'd0, viol_cause}, 32'h2);
      step();
      clr_cause = 1'b1; data_en = 1'b1; data_addr = 16'h016A;
      step();
      clr_cause = 1'b0; data_en = 1'b0;
      check("clrhit_cause", {30'd0, viol_cause}, 32'h1);
      check("clrhit_src",   {30'd0, viol_src},   32'h1);
      check("clrhit_cnt",   {24'd0, viol_cnt},   {24'd0, exp_cnt1});

      // Asynchronous reset mid-EXEC.
      step();
      reset_n = 1'b0;
      #1;
      check("async_rst_exec",  {31'd0, exec}, 32'd0);
      check("async_rst_cause", {30'd0, viol_cause}, 32'd0);
      check("async_rst_src",   {30'd0, viol_src}, 32'd0);
      check("async_rst_cnt",   {24'd0, viol_cnt}, 32'd0);
      step();
      step();
      pc = 16'h1234;
      reset_n = 1'b1;
      #1;
      check("release_exec", {31'd0, exec}, 32'd0);
      step();
      check("release_exec_hold", {31'd0, exec}, 32'd0);

      // Randomized phase, checked every cycle by the model.
      for (int n = 0; n < 3000; n++) begin
         step();
         if (n % 200 == 0) randomize_regions();
         pc        = ($urandom_range(0, 2) == 0) ? er_min : AW'($urandom);
         data_en   = ($urandom_range(0, 3) == 0);
         data_addr = pick_addr();
         dma_en    = ($urandom_range(0, 4) == 0);
         dma_addr  = pick_addr();
         clr_cause = ($urandom_range(0, 15) == 0);
      end
      step();
      data_en = 1'b0; dma_en = 1'b0; clr_cause = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
